video_pattern_gen: RTL and testbench

//  Parametrised testcard generator; feeds 1-bit pixel to video_raw (i_pixel) from its o_pixel_x/y/o_enable.
//  8 selectable patterns, frame-synchronous auto-cycling and scrolling, manual hold/step control.

---
 rtl/video_pattern_gen_pkg.sv | 32 +++
 rtl/video_pattern_gen_divider.sv | 31 +++
 rtl/video_pattern_gen.sv | 99 +++++++++
 tb/tb_video_pattern_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the testcard generator: mode encoding and the small built-in glyph table.
package video_pattern_gen_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_GRID    = 3'd0,
    MODE_SCROLL  = 3'd1,
    MODE_TEXT    = 3'd2,
    MODE_SOLID   = 3'd3,
    MODE_HLINES  = 3'd4,
    MODE_VLINES  = 3'd5,
    MODE_CHECKER = 3'd6,
    MODE_BORDER  = 3'd7
  } mode_e;

  // 6x8 glyphs, MSB leftmost; the character row repeats "TEST" then four blanks.
  function automatic logic [5:0] fontRow(input logic [2:0] glyph, input logic [2:0] row);
    logic [47:0] bits;
    case (glyph)
      3'd0, 3'd3: bits = {6'b111110, 6'b001000, 6'b001000, 6'b001000,
                          6'b001000, 6'b001000, 6'b001000, 6'b000000};
      3'd1:       bits = {6'b111110, 6'b100000, 6'b100000, 6'b111100,
                          6'b100000, 6'b100000, 6'b111110, 6'b000000};
      3'd2:       bits = {6'b011110, 6'b100000, 6'b100000, 6'b011100,
                          6'b000010, 6'b000010, 6'b111100, 6'b000000};
      default:    bits = 48'd0;
    endcase
    return bits[(3'd7 - row) * 6 +: 6];
  endfunction

endpackage

// File: rtl/video_pattern_gen_divider.sv
// Frame-count divider: counts ticks and pulses o_wrap combinationally on the tick that completes LIMIT.
module video_frame_divider #(
  parameter int LIMIT = 2,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_hold,
  input  logic i_clear,
  output logic o_wrap
);

  logic [WIDTH-1:0] r_count;
  logic             w_atLimit;

  assign w_atLimit = (r_count == WIDTH'(LIMIT - 1));
  assign o_wrap    = i_tick & ~i_hold & w_atLimit;

  // Clear wins over counting so a manual step restarts the full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick & ~i_hold) begin
      r_count <= w_atLimit ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Testcard generator: frame-synchronous mode/scroll state, pattern mux and registered 1-bit pixel.
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int X_W           = 9,
  parameter int Y_W           = 8,
  parameter int GRID_LOG2     = 3,
  parameter int MODE_FRAMES   = 250,
  parameter int SCROLL_FRAMES = 2,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [X_W-1:0]    i_pixel_x,
  input  logic [Y_W-1:0]    i_pixel_y,
  input  logic              i_frame_start,
  input  logic              i_hold,
  input  logic              i_step,
  output logic              o_pixel,
  output logic [MODE_W-1:0] o_mode
);

  mode_e                r_mode;
  logic [GRID_LOG2-1:0] r_offset;
  logic                 r_pixel;

  logic                 w_scrollWrap;
  logic                 w_modeWrap;
  logic [GRID_LOG2-1:0] w_xLow;
  logic [GRID_LOG2-1:0] w_yLow;
  logic [GRID_LOG2-1:0] w_xScroll;
  logic [GRID_LOG2-1:0] w_yScroll;
  logic [2:0]           w_col;
  logic [5:0]           w_fontRow;
  logic                 w_pattern;

  video_frame_divider #(.LIMIT(SCROLL_FRAMES), .WIDTH(FRAME_CNT_W)) u_scrollDiv (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (i_frame_start),
    .i_hold  (1'b0),
    .i_clear (1'b0),
    .o_wrap  (w_scrollWrap)
  );

  video_frame_divider #(.LIMIT(MODE_FRAMES), .WIDTH(FRAME_CNT_W)) u_modeDiv (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (i_frame_start),
    .i_hold  (i_hold),
    .i_clear (i_step),
    .o_wrap  (w_modeWrap)
  );

  // A step coinciding with an auto wrap still advances the mode only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= MODE_GRID;
      r_offset <= '0;
    end else begin
      if (i_step | w_modeWrap) r_mode <= mode_e'(r_mode + 1'b1);
      if (w_scrollWrap)        r_offset <= r_offset + 1'b1;
    end
  end

  // Only the low grid bits matter for the grid tests, so the scroll add stays narrow.
  assign w_xLow    = i_pixel_x[GRID_LOG2-1:0];
  assign w_yLow    = i_pixel_y[GRID_LOG2-1:0];
  assign w_xScroll = w_xLow + r_offset;
  assign w_yScroll = w_yLow + r_offset;
  assign w_col     = 3'(i_pixel_x % X_W'(6));
  assign w_fontRow = fontRow(i_pixel_y[5:3], i_pixel_y[2:0]);

  always_comb begin
    w_pattern = 1'b0;
    case (r_mode)
      MODE_GRID:    w_pattern = (w_yLow == '0) || (w_xLow == '0);
      MODE_SCROLL:  w_pattern = (w_yScroll == '0) || (w_xScroll == '0);
      MODE_TEXT:    w_pattern = w_fontRow[3'd5 - w_col];
      MODE_SOLID:   w_pattern = 1'b1;
      MODE_HLINES:  w_pattern = ~i_pixel_y[0];
      MODE_VLINES:  w_pattern = ~i_pixel_x[0];
      MODE_CHECKER: w_pattern = i_pixel_x[GRID_LOG2] ^ i_pixel_y[GRID_LOG2];
      MODE_BORDER:  w_pattern = (i_pixel_x == '0) || (i_pixel_y == '0) ||
                                (i_pixel_x == '1) || (i_pixel_y == '1);
      default:      w_pattern = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pixel <= 1'b0;
    else     r_pixel <= i_enable & w_pattern;
  end

  assign o_pixel = r_pixel;
  assign o_mode  = r_mode;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: vector table for the pattern mux plus frame-timing sequences.
module tb_video_pattern_gen;

  logic       clk;
  logic       rst;
  logic       i_enable;
  logic [8:0] i_pixel_x;
  logic [7:0] i_pixel_y;
  logic       i_frame_start;
  logic       i_hold;
  logic       i_step;
  logic       o_pixel;
  logic [2:0] o_mode;

  int checks = 0;
  int errors = 0;
  int curMode = 0;
  logic expQ[$];

  typedef struct {
    logic [2:0] mode;
    logic       en;
    logic [8:0] x;
    logic [7:0] y;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  video_pattern_gen #(
    .X_W(9), .Y_W(8), .GRID_LOG2(3),
    .MODE_FRAMES(3), .SCROLL_FRAMES(2), .FRAME_CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_pixel_x     (i_pixel_x),
    .i_pixel_y     (i_pixel_y),
    .i_frame_start (i_frame_start),
    .i_hold        (i_hold),
    .i_step        (i_step),
    .o_pixel       (o_pixel),
    .o_mode        (o_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    logic e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %0d", name, o_pixel);
    end else begin
      e = expQ.pop_front();
      checkValue(name, int'(o_pixel), int'(e));
    end
  endtask

  // Called at a negedge; drives one pixel and checks the registered result one clock later.
  task automatic applyStimulus(input logic en, input logic [8:0] x, input logic [7:0] y,
                               input logic frame, input logic exp, input string name);
    i_enable      = en;
    i_pixel_x     = x;
    i_pixel_y     = y;
    i_frame_start = frame;
    expQ.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    i_frame_start = 1'b0;
    i_enable      = 1'b0;
    checkOutput(name);
  endtask

  task automatic stepMode(input int n);
    for (int k = 0; k < n; k++) begin
      i_step = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_step = 1'b0;
      curMode = (curMode + 1) % 8;
    end
  endtask

  task automatic frameTick(input logic withStep);
    i_frame_start = 1'b1;
    i_step        = withStep;
    @(posedge clk);
    @(negedge clk);
    i_frame_start = 1'b0;
    i_step        = 1'b0;
  endtask

  task automatic addVec(input logic [2:0] m, input logic en, input logic [8:0] x,
                        input logic [7:0] y, input logic exp);
    vec_t v;
    v.mode = m; v.en = en; v.x = x; v.y = y; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    addVec(3'd0, 1, 9'd0,   8'd5,   1);
    addVec(3'd0, 1, 9'd3,   8'd5,   0);
    addVec(3'd0, 1, 9'd9,   8'd8,   1);
    addVec(3'd0, 1, 9'd9,   8'd9,   0);
    addVec(3'd1, 1, 9'd5,   8'd2,   0);
    addVec(3'd1, 1, 9'd1,   8'd0,   1);
    addVec(3'd2, 1, 9'd0,   8'd0,   1);
    addVec(3'd2, 1, 9'd5,   8'd0,   0);
    addVec(3'd2, 1, 9'd6,   8'd0,   1);
    addVec(3'd2, 1, 9'd0,   8'd9,   1);
    addVec(3'd2, 1, 9'd1,   8'd9,   0);
    addVec(3'd2, 1, 9'd1,   8'd16,  1);
    addVec(3'd2, 1, 9'd0,   8'd16,  0);
    addVec(3'd3, 1, 9'd100, 8'd100, 1);
    addVec(3'd3, 0, 9'd100, 8'd100, 0);
    addVec(3'd4, 1, 9'd1,   8'd2,   1);
    addVec(3'd4, 1, 9'd1,   8'd3,   0);
    addVec(3'd5, 1, 9'd4,   8'd1,   1);
    addVec(3'd5, 1, 9'd7,   8'd1,   0);
    addVec(3'd6, 1, 9'd8,   8'd0,   1);
    addVec(3'd6, 1, 9'd8,   8'd8,   0);
    addVec(3'd6, 1, 9'd0,   8'd8,   1);
    addVec(3'd7, 1, 9'd511, 8'd10,  1);
    addVec(3'd7, 1, 9'd510, 8'd10,  0);
    addVec(3'd7, 1, 9'd5,   8'd255, 1);
    addVec(3'd7, 0, 9'd5,   8'd0,   0);
    addVec(3'd7, 1, 9'd5,   8'd0,   1);

    rst = 1'b1; i_enable = 1'b0; i_pixel_x = '0; i_pixel_y = '0;
    i_frame_start = 1'b0; i_hold = 1'b0; i_step = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("reset_pixel", int'(o_pixel), 0);
    checkValue("reset_mode", int'(o_mode), 0);
    rst = 1'b0;
    @(negedge clk);

    // Pattern table
    foreach (vecs[i]) begin
      if (int'(vecs[i].mode) != curMode) begin
        stepMode((int'(vecs[i].mode) - curMode + 8) % 8);
        checkValue("table_mode", int'(o_mode), int'(vecs[i].mode));
      end
      applyStimulus(vecs[i].en, vecs[i].x, vecs[i].y, 1'b0, vecs[i].exp,
                    $sformatf("table_%0d_mode%0d", i, vecs[i].mode));
    end

    // Hold across frames: mode frozen, scroll keeps stepping every two frames
    stepMode(2);
    checkValue("hold_start_mode", int'(o_mode), 1);
    i_hold = 1'b1;
    repeat (6) frameTick(1'b0);
    checkValue("hold_mode_6", int'(o_mode), 1);
    applyStimulus(1, 9'd5, 8'd2, 1'b0, 1, "scroll_off3_x5");
    applyStimulus(1, 9'd4, 8'd2, 1'b0, 0, "scroll_off3_x4");
    repeat (4) frameTick(1'b0);
    checkValue("hold_mode_10", int'(o_mode), 1);
    applyStimulus(1, 9'd3, 8'd2, 1'b0, 1, "scroll_off5_x3");
    repeat (4) frameTick(1'b0);
    applyStimulus(1, 9'd1, 8'd2, 1'b0, 1, "scroll_off7_x1");
    repeat (2) frameTick(1'b0);
    applyStimulus(1, 9'd0, 8'd3, 1'b0, 1, "scroll_wrap_x0");
    applyStimulus(1, 9'd1, 8'd3, 1'b0, 0, "scroll_wrap_x1");
    checkValue("hold_mode_16", int'(o_mode), 1);
    i_hold = 1'b0;

    // Auto cycling every three frames, including the 7 -> 0 wrap
    repeat (2) frameTick(1'b0);
    checkValue("auto_before", int'(o_mode), 1);
    frameTick(1'b0);
    checkValue("auto_first", int'(o_mode), 2);
    for (int k = 0; k < 8; k++) begin
      repeat (3) frameTick(1'b0);
      checkValue($sformatf("auto_cycle_%0d", k), int'(o_mode), (3 + k) % 8);
    end

    // Step coincident with the wrapping frame advances once and restarts the period
    repeat (2) frameTick(1'b0);
    frameTick(1'b1);
    checkValue("coincident_step", int'(o_mode), 3);
    repeat (2) frameTick(1'b0);
    checkValue("after_coincident_2", int'(o_mode), 3);
    frameTick(1'b0);
    checkValue("after_coincident_3", int'(o_mode), 4);

    // Pixel on a mode-changing frame_start cycle uses the old mode
    repeat (2) frameTick(1'b0);
    applyStimulus(1, 9'd1, 8'd0, 1'b1, 1, "frame_edge_old_mode");
    checkValue("frame_edge_new_mode", int'(o_mode), 5);
    applyStimulus(1, 9'd1, 8'd0, 1'b0, 0, "frame_edge_next_pixel");

    // Reset in the middle of an active line
    curMode = 5;
    stepMode(6);
    checkValue("pre_reset_mode", int'(o_mode), 3);
    i_enable = 1'b1; i_pixel_x = 9'd10; i_pixel_y = 8'd10;
    @(posedge clk);
    #2;
    checkValue("pre_reset_pixel", int'(o_pixel), 1);
    rst = 1'b1;
    #1;
    checkValue("midline_reset_pixel", int'(o_pixel), 0);
    checkValue("midline_reset_mode", int'(o_mode), 0);
    @(negedge clk);
    rst = 1'b0;
    i_enable = 1'b0;
    curMode = 0;
    applyStimulus(1, 9'd0, 8'd0, 1'b0, 1, "post_reset_origin");
    checkValue("post_reset_mode", int'(o_mode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
